pipe_stage_queue: RTL

- Parametrised inter-stage buffer, the successor to the single-slot valid/allowin stage links (IF->ID, ID->EXE, EXE->MEM, MEM->WB).
- Holds up to DEPTH bus entries in FIFO order.
- Uses the same valid/allowin handshake as existing stages.
- Adds a flush (branch/exception cancel) and an occupancy readout; sits between any two stages, first use is fs_to_ds.

---
 rtl/pipe_stage_queue_pkg.sv | 30 +++
 rtl/pipe_queue_ram.sv | 29 ++
 rtl/pipe_stage_queue.sv | 113 +++++++++++
 3 files changed

// File: rtl/pipe_stage_queue_pkg.sv
// Shared definitions for the inter-stage queues: link bus widths and the
// handshake equations used by every queue instance.
package pipe_stage_queue_pkg;

    // Bus widths of the pipeline links, so queue instances and stages agree.
    localparam int FS_TO_DS_BUS_W = 64;
    localparam int DS_TO_ES_BUS_W = 163;
    localparam int ES_TO_MS_BUS_W = 76;
    localparam int MS_TO_WS_BUS_W = 70;
    localparam int WS_TO_RF_BUS_W = 38;
    localparam int BR_BUS_W       = 33;

    // A transfer happens when the offer is valid, the receiver accepts, and
    // no flush cancels it in the same cycle.
    function automatic logic link_fire(input logic valid,
                                       input logic accept,
                                       input logic cancel);
        return valid & accept & ~cancel;
    endfunction

    // Upstream-facing allowin. With pass_en set, a full queue may still
    // accept when the head leaves in the same cycle. Flush never gates it.
    function automatic logic link_allowin(input logic ready,
                                          input logic full,
                                          input logic down_allowin,
                                          input logic pass_en);
        return ready & (~full | (pass_en & down_allowin));
    endfunction

endpackage

// File: rtl/pipe_queue_ram.sv
// Entry storage for pipe_stage_queue: DEPTH x BUS_W register array with one
// synchronous write port and one asynchronous read port. Contents are not
// reset; the queue only exposes entries it has written.
module pipe_queue_ram #(
    parameter int BUS_W = 64,
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [BUS_W-1:0] wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [BUS_W-1:0] rdata_o
);

    logic [BUS_W-1:0] mem_q [DEPTH];

    // Write the pushed entry into its slot.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Head entry read straight from storage.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_stage_queue.sv
// Multi-entry FIFO link between two pipeline stages.
//
// Handshake: an entry moves upstream->queue on a clock edge when
// in_valid & allowin & ~flush, and queue->downstream when
// out_valid & out_allowin & ~flush. allowin is a function of occupancy
// (and out_allowin when PASS_ALLOWIN=1) only, never of in_valid or flush;
// out_valid is simply "not empty". A pushed entry becomes the visible head
// no earlier than the edge after it was accepted (no bypass path).
module pipe_stage_queue #(
    parameter int BUS_W        = 64,
    parameter int DEPTH        = 2,
    parameter int PASS_ALLOWIN = 1,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [BUS_W-1:0] in_bus,
    output logic             allowin,
    output logic             out_valid,
    output logic [BUS_W-1:0] out_bus,
    input  logic             out_allowin,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    import pipe_stage_queue_pkg::*;

    localparam int   PTR_W   = $clog2(DEPTH);
    localparam logic PASS_EN = (PASS_ALLOWIN != 0);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    // Low during reset and until the first edge after release, so allowin
    // stays low across that window.
    logic             ready_q;

    logic push;
    logic pop;

    // Occupancy-derived status.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign out_valid = ~empty;

    assign allowin = link_allowin(ready_q, full, out_allowin, PASS_EN);
    assign push    = link_fire(in_valid, allowin, flush);
    assign pop     = link_fire(out_valid, out_allowin, flush);

    // Next pointers and count; flush wins over any push or pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers, cleared immediately on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Upstream acceptance is enabled from the first edge after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    pipe_queue_ram #(
        .BUS_W (BUS_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_bus),
        .raddr_i (rd_ptr_q),
        .rdata_o (out_bus)
    );

endmodule
